// File: rtl/hr_cordic_log2.sv
// Iterative hyperbolic CORDIC (vectoring mode) computing log2 of a float as E + log2(m).
// Angles are atanh(2^-k)/ln2 scaled by 2^27, so the final z equals log2(m)/2.
module hr_cordic_log2 #(
   parameter int unsigned W    = 30,
   parameter int unsigned FRAC = 27,
   parameter int unsigned EW   = 9,
   parameter int unsigned ITER = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W-1:0]         m_in,
   input  logic [EW-1:0]        e_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EW+FRAC-1:0]   log2_out,
   output logic [W-1:0]         frac_out,
   output logic [EW-1:0]        e_out,
   output logic                 range_err
);

   localparam int unsigned LW = EW + FRAC;
   localparam int unsigned CW = 5;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FINAL = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [W-1:0] ONE = W'(1) << FRAC;

   // Shift schedule 1,2,3,4,4,5..13,13,14..22 indexed by iteration count.
   function automatic logic [CW-1:0] shift_of(input logic [CW-1:0] c);
      if (c < CW'(4))       return c + CW'(1);
      else if (c < CW'(14)) return c;
      else                  return c - CW'(1);
   endfunction

   // atanh(2^-k)/ln2 * 2^27, shared with the exp stage of the Nth-root path.
   function automatic logic [W-1:0] atanh_of(input logic [CW-1:0] k);
      case (k)
         5'd1:    return W'(32'h06570069);
         5'd2:    return W'(32'h02F2A71C);
         5'd3:    return W'(32'h01734592);
         5'd4:    return W'(32'h00B8E7EE);
         5'd5:    return W'(32'h005C5CD0);
         5'd6:    return W'(32'h002E2B85);
         5'd7:    return W'(32'h00171566);
         5'd8:    return W'(32'h000B8AA8);
         5'd9:    return W'(32'h0005C552);
         5'd10:   return W'(32'h0002E2A9);
         5'd11:   return W'(32'h00017154);
         5'd12:   return W'(32'h0000B8AA);
         5'd13:   return W'(32'h00005C55);
         5'd14:   return W'(32'h00002E2B);
         5'd15:   return W'(32'h00001715);
         5'd16:   return W'(32'h00000B8B);
         5'd17:   return W'(32'h000005C5);
         5'd18:   return W'(32'h000002E3);
         5'd19:   return W'(32'h00000171);
         5'd20:   return W'(32'h000000B9);
         5'd21:   return W'(32'h0000005C);
         5'd22:   return W'(32'h0000002E);
         default: return '0;
      endcase
   endfunction

   logic [1:0]          state, state_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic signed [W-1:0] x, y, z;
   logic signed [W-1:0] x_nxt, y_nxt, z_nxt;
   logic [EW-1:0]       e_nxt;
   logic                rerr_nxt;
   logic                ov_nxt;
   logic [LW-1:0]       log_nxt;
   logic [W-1:0]        frac_nxt;
   logic [CW-1:0]       k;
   logic [W-1:0]        ang;
   logic signed [W-1:0] xs, ys, zs;

   // Ready only in IDLE and never while reset is asserted.
   assign in_ready = (state == S_IDLE) && !rst;

   // Next-state, datapath iteration and output updates.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      x_nxt     = x;
      y_nxt     = y;
      z_nxt     = z;
      e_nxt     = e_out;
      rerr_nxt  = range_err;
      ov_nxt    = out_valid;
      log_nxt   = log2_out;
      frac_nxt  = frac_out;
      k         = shift_of(cnt);
      ang       = atanh_of(k);
      xs        = x >>> k;
      ys        = y >>> k;
      zs        = z <<< 1;

      case (state)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               x_nxt     = m_in + ONE;
               y_nxt     = m_in - ONE;
               z_nxt     = '0;
               cnt_nxt   = '0;
               e_nxt     = e_in;
               rerr_nxt  = (m_in[W-1:FRAC] != (W-FRAC)'(1));
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            // Both updates use the pre-edge x and y.
            if (!y[W-1]) begin
               x_nxt = x - ys;
               y_nxt = y - xs;
               z_nxt = z + ang;
            end else begin
               x_nxt = x + ys;
               y_nxt = y + xs;
               z_nxt = z - ang;
            end
            cnt_nxt = cnt + CW'(1);
            if (cnt == CW'(ITER - 1)) state_nxt = S_FINAL;
         end
         S_FINAL: begin
            frac_nxt  = zs;
            log_nxt   = {e_out, {FRAC{1'b0}}} + {{(LW-W){zs[W-1]}}, zs};
            ov_nxt    = 1'b1;
            state_nxt = S_DONE;
         end
         default: begin
            if (out_ready) begin
               ov_nxt    = 1'b0;
               state_nxt = S_IDLE;
            end
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         x         <= '0;
         y         <= '0;
         z         <= '0;
         e_out     <= '0;
         range_err <= 1'b0;
         out_valid <= 1'b0;
         log2_out  <= '0;
         frac_out  <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         x         <= x_nxt;
         y         <= y_nxt;
         z         <= z_nxt;
         e_out     <= e_nxt;
         range_err <= rerr_nxt;
         out_valid <= ov_nxt;
         log2_out  <= log_nxt;
         frac_out  <= frac_nxt;
      end
   end

endmodule

// File: tb/tb_hr_cordic_log2.sv
// Scoreboard bench for hr_cordic_log2 against a real-valued log2 model.
module tb_hr_cordic_log2;

   localparam int unsigned W    = 30;
   localparam int unsigned EW   = 9;
   localparam int unsigned LW   = 36;
   localparam longint      TOL  = 128;
   localparam real         SCL  = 134217728.0;

   typedef struct {
      logic [W-1:0]         m;
      logic signed [EW-1:0] e;
      bit                   rerr;
      longint               acc;
   } op_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  m_in;
   logic [EW-1:0] e_in;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [LW-1:0] log2_out;
   logic [W-1:0]  frac_out;
   logic [EW-1:0] e_out;
   logic          range_err;

   int     checks   = 0;
   int     failures = 0;
   longint cyc      = 0;
   bit     rdy_rand  = 1'b0;
   bit     rdy_force = 1'b0;
   bit     prev_ov   = 1'b0;
   op_t    q[$];

   hr_cordic_log2 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .m_in      (m_in),
      .e_in      (e_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .log2_out  (log2_out),
      .frac_out  (frac_out),
      .e_out     (e_out),
      .range_err (range_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready: random or directed, changed just after the edge.
   always @(posedge clk) begin
      #1;
      out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
   end

   task automatic chk(input string name, input bit ok, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic real log2_of(input logic [W-1:0] m);
      return $ln(real'(m) / SCL) / $ln(2.0);
   endfunction

   function automatic longint exp_full(input logic [W-1:0] m, input logic signed [EW-1:0] e);
      return longint'(real'(e) * SCL + log2_of(m) * SCL);
   endfunction

   // Difference folded into the signed 36-bit result range.
   function automatic longint wrap36(input longint d);
      longint r;
      r = d & 64'h0000000FFFFFFFFF;
      if (r >= 64'sd34359738368) r = r - 64'sd68719476736;
      return r;
   endfunction

   task automatic check_result(input op_t o);
      longint ex, got, d, ef, gf;
      chk("range_err", range_err == o.rerr, range_err, o.rerr);
      chk("e_out", $signed(e_out) == o.e, $signed(e_out), o.e);
      if (!o.rerr) begin
         ex  = exp_full(o.m, o.e);
         got = longint'($signed(log2_out));
         d   = wrap36(got - ex);
         chk("log2_out", (d <= TOL) && (d >= -TOL), got, ex);
         ef  = longint'(log2_of(o.m) * SCL);
         gf  = longint'($signed(frac_out));
         chk("frac_out", (gf - ef <= TOL) && (ef - gf <= TOL), gf, ef);
      end
   endtask

   // Monitor: latency on the rising out_valid, full check at each handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && !prev_ov) begin
            if (q.size() == 0) chk("spurious_valid", 1'b0, 1, 0);
            else chk("latency", (cyc - q[0].acc) == 25, cyc - q[0].acc, 25);
         end
         if (out_valid && out_ready && q.size() > 0) check_result(q.pop_front());
      end
      prev_ov = out_valid;
   end

   task automatic issue(input logic [W-1:0] m, input logic [EW-1:0] e);
      int  t;
      op_t o;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      m_in     = m;
      e_in     = e;
      t        = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!in_ready && t < 200);
      if (!in_ready) begin
         chk("accept_timeout", 1'b0, t, 200);
      end else begin
         o.m    = m;
         o.e    = $signed(e);
         o.rerr = (m[W-1:27] != 3'b001);
         o.acc  = cyc + 1;
         q.push_back(o);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input int bound);
      int t;
      t = 0;
      while (q.size() > 0 && t < bound) begin
         @(negedge clk);
         t++;
      end
      chk("drain", q.size() == 0, q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      longint bp_exp, got;
      int     t, hi;
      rst      = 1'b1;
      in_valid = 1'b0;
      m_in     = '0;
      e_in     = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready == 1'b0, in_ready, 0);
      chk("rst_out_valid", out_valid == 1'b0, out_valid, 0);
      chk("rst_log2_out", log2_out == '0, log2_out, 0);
      chk("rst_frac_out", frac_out == '0, frac_out, 0);
      chk("rst_e_out", e_out == '0, e_out, 0);
      chk("rst_range_err", range_err == 1'b0, range_err, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", in_ready == 1'b1, in_ready, 1);

      // Directed operands with downstream always ready.
      rdy_force = 1'b1;
      issue(30'h08000000, 9'd0);      drain(200);
      issue(30'h0C000000, 9'd3);      drain(200);
      issue(30'h0FFFFFFF, 9'h1FF);    drain(200);
      issue(30'h0FFFFFFF, 9'h100);    drain(200);
      issue(30'h0FFFFFFF, 9'd255);    drain(200);
      issue(30'h08000000, 9'h100);    drain(200);
      issue(30'h04000000, 9'd0);      drain(200);

      // Backpressure: hold the result for 10 cycles, then a 1-cycle ready.
      @(negedge clk);
      rdy_force = 1'b0;
      issue(30'h0C000000, 9'd1);
      bp_exp = exp_full(30'h0C000000, 9'sd1);
      t = 0;
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("bp_wait", out_valid == 1'b1, out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         got = longint'($signed(log2_out));
         chk("bp_valid", out_valid == 1'b1, out_valid, 1);
         chk("bp_in_ready", in_ready == 1'b0, in_ready, 0);
         chk("bp_log2_hold", (got - bp_exp <= TOL) && (bp_exp - got <= TOL), got, bp_exp);
      end
      rdy_force = 1'b1;
      @(negedge clk);
      rdy_force = 1'b0;
      @(negedge clk);
      chk("bp_release_valid", out_valid == 1'b0, out_valid, 0);
      chk("bp_release_ready", in_ready == 1'b1, in_ready, 1);
      drain(10);

      // Reset in the middle of an operation aborts it silently.
      rdy_force = 1'b1;
      issue(30'h08000000, 9'd5);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      chk("abort_in_ready", in_ready == 1'b0, in_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      hi = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) hi++;
      end
      chk("abort_no_valid", hi == 0, hi, 0);
      issue(30'h0C000000, 9'd0);
      drain(200);

      // Random legal operands with random input gaps and output backpressure.
      rdy_rand = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         issue(W'(32'h08000000 + $urandom_range(0, 32'h07FFFFFF)), EW'($urandom));
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      drain(400);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
